// File: rtl/bip_run_controller.sv
// Sequences one BIP2 core: streams a program into instruction memory, holds the core in reset,
// then runs it until an HLT opcode is fetched or the cycle limit expires.
module bip_run_controller #(
   parameter int unsigned OPERAND_ADDRESS_WIDTH  = 11,
   parameter int unsigned INSTRUCTION_DATA_WIDTH = 16,
   parameter int unsigned OPCODE_WIDTH           = 5,
   parameter int unsigned HLT_OPCODE             = 0,
   parameter int unsigned CYCLE_COUNT_WIDTH      = 24,
   parameter int unsigned CLEAR_CYCLES           = 2
) (
   input  logic                              clock_in,
   input  logic                              reset_in,
   input  logic                              load_start_in,
   input  logic                              load_valid_in,
   input  logic [INSTRUCTION_DATA_WIDTH-1:0] load_data_in,
   input  logic                              load_last_in,
   output logic                              load_ready_out,
   input  logic                              run_start_in,
   input  logic [CYCLE_COUNT_WIDTH-1:0]      max_cycles_in,
   input  logic [OPERAND_ADDRESS_WIDTH-1:0]  core_instruction_address_in,
   input  logic [INSTRUCTION_DATA_WIDTH-1:0] core_instruction_in,
   output logic                              core_reset_out,
   output logic                              imem_wr_out,
   output logic [OPERAND_ADDRESS_WIDTH-1:0]  imem_address_out,
   output logic [INSTRUCTION_DATA_WIDTH-1:0] imem_data_out,
   output logic                              busy_out,
   output logic                              done_out,
   output logic                              timeout_out,
   output logic [OPERAND_ADDRESS_WIDTH-1:0]  halt_address_out,
   output logic [CYCLE_COUNT_WIDTH-1:0]      cycle_count_out,
   output logic [OPERAND_ADDRESS_WIDTH:0]    loaded_words_out
);

   localparam int unsigned Oaw  = OPERAND_ADDRESS_WIDTH;
   localparam int unsigned Idw  = INSTRUCTION_DATA_WIDTH;
   localparam int unsigned Opw  = OPCODE_WIDTH;
   localparam int unsigned Ccw  = CYCLE_COUNT_WIDTH;
   localparam int unsigned ClrW = $clog2(CLEAR_CYCLES + 1);
   localparam logic [Opw-1:0]  HltOp   = Opw'(HLT_OPCODE);
   localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StLoad, StClear, StRun, StDone, StTimeout
   } state_e;

   state_e          state_q, state_d;
   logic [Oaw-1:0]  ptr_q, ptr_d;
   logic [Oaw:0]    loaded_q, loaded_d;
   logic [ClrW-1:0] clr_q, clr_d;
   logic [Ccw-1:0]  count_q, count_d;
   logic [Ccw-1:0]  limit_q, limit_d;
   logic [Oaw-1:0]  halt_q, halt_d;
   logic            load_ready_q, load_ready_d;
   logic            core_reset_q, core_reset_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            timeout_q, timeout_d;

   logic            handshake;
   logic            is_hlt;
   logic [Ccw-1:0]  count_inc;
   logic            unused_instr_low;

   assign handshake        = load_ready_q & load_valid_in;
   assign is_hlt           = core_instruction_in[Idw-1 -: Opw] == HltOp;
   assign count_inc        = (&count_q) ? count_q : count_q + Ccw'(1);
   assign unused_instr_low = ^core_instruction_in[Idw-Opw-1:0];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      loaded_d = loaded_q;
      clr_d    = clr_q;
      count_d  = count_q;
      limit_d  = limit_q;
      halt_d   = halt_q;
      unique case (state_q)
         StIdle, StDone, StTimeout: begin
            if (load_start_in) begin
               state_d  = StLoad;
               ptr_d    = '0;
               loaded_d = '0;
            end else if (run_start_in) begin
               state_d = StClear;
               clr_d   = '0;
               count_d = '0;
               limit_d = max_cycles_in;
            end
         end
         StLoad: begin
            if (handshake) begin
               loaded_d = loaded_q + (Oaw + 1)'(1);
               // The pointer parks at the top address instead of wrapping.
               if (!(&ptr_q)) ptr_d = ptr_q + Oaw'(1);
               if (load_last_in || (&ptr_q)) state_d = StIdle;
            end
         end
         StClear: begin
            clr_d = clr_q + ClrW'(1);
            if (clr_q == ClrLast) state_d = StRun;
         end
         StRun: begin
            count_d = count_inc;
            if (is_hlt) begin
               state_d = StDone;
               halt_d  = core_instruction_address_in;
            end else if ((limit_q != '0) && (count_inc == limit_q)) begin
               state_d = StTimeout;
            end
         end
         default: state_d = StIdle;
      endcase
      load_ready_d = state_d == StLoad;
      core_reset_d = state_d != StRun;
      busy_d       = state_d inside {StLoad, StClear, StRun};
      done_d       = state_d == StDone;
      timeout_d    = state_d == StTimeout;
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         loaded_q     <= '0;
         clr_q        <= '0;
         count_q      <= '0;
         limit_q      <= '0;
         halt_q       <= '0;
         load_ready_q <= 1'b0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         loaded_q     <= loaded_d;
         clr_q        <= clr_d;
         count_q      <= count_d;
         limit_q      <= limit_d;
         halt_q       <= halt_d;
         load_ready_q <= load_ready_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   // Write strobe is suppressed while reset is asserted even if a handshake is presented.
   assign imem_wr_out      = handshake & ~reset_in;
   assign imem_address_out = (state_q == StLoad) ? ptr_q : core_instruction_address_in;
   assign imem_data_out    = load_data_in;

   assign load_ready_out   = load_ready_q;
   assign core_reset_out   = core_reset_q;
   assign busy_out         = busy_q;
   assign done_out         = done_q;
   assign timeout_out      = timeout_q;
   assign halt_address_out = halt_q;
   assign cycle_count_out  = count_q;
   assign loaded_words_out = loaded_q;

endmodule

// File: tb/tb_bip_run_controller.sv
// Scoreboard bench for bip_run_controller: a fake core/memory, a program-level run model,
// and a negedge monitor that pops expected writes, load completions and run results.
module tb_bip_run_controller;

   localparam int unsigned Oaw         = 11;
   localparam int unsigned Idw         = 16;
   localparam int unsigned Ccw         = 24;
   localparam int unsigned ClearCycles = 2;
   localparam int unsigned MemWords    = 2048;

   logic             clk = 1'b0;
   logic             reset_in = 1'b1;
   logic             load_start_in = 1'b0;
   logic             load_valid_in = 1'b0;
   logic [Idw-1:0]   load_data_in = '0;
   logic             load_last_in = 1'b0;
   logic             load_ready_out;
   logic             run_start_in = 1'b0;
   logic [Ccw-1:0]   max_cycles_in = '0;
   logic [Oaw-1:0]   core_instruction_address_in;
   logic [Idw-1:0]   core_instruction_in;
   logic             core_reset_out;
   logic             imem_wr_out;
   logic [Oaw-1:0]   imem_address_out;
   logic [Idw-1:0]   imem_data_out;
   logic             busy_out;
   logic             done_out;
   logic             timeout_out;
   logic [Oaw-1:0]   halt_address_out;
   logic [Ccw-1:0]   cycle_count_out;
   logic [Oaw:0]     loaded_words_out;

   always #5 clk = ~clk;

   bip_run_controller dut (
      .clock_in                    (clk),
      .reset_in                    (reset_in),
      .load_start_in               (load_start_in),
      .load_valid_in               (load_valid_in),
      .load_data_in                (load_data_in),
      .load_last_in                (load_last_in),
      .load_ready_out              (load_ready_out),
      .run_start_in                (run_start_in),
      .max_cycles_in               (max_cycles_in),
      .core_instruction_address_in (core_instruction_address_in),
      .core_instruction_in         (core_instruction_in),
      .core_reset_out              (core_reset_out),
      .imem_wr_out                 (imem_wr_out),
      .imem_address_out            (imem_address_out),
      .imem_data_out               (imem_data_out),
      .busy_out                    (busy_out),
      .done_out                    (done_out),
      .timeout_out                 (timeout_out),
      .halt_address_out            (halt_address_out),
      .cycle_count_out             (cycle_count_out),
      .loaded_words_out            (loaded_words_out)
   );

   // Fake core: PC is 0 under reset and advances once per released cycle.
   logic [Idw-1:0] mem [MemWords];
   bit             mem_init_done;
   logic [Oaw-1:0] pc = '0;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < int'(MemWords); i++) mem[i] <= 16'hF800;
         mem_init_done <= 1'b1;
      end else if (imem_wr_out === 1'b1) begin
         mem[imem_address_out] <= imem_data_out;
      end
      pc <= (core_reset_out !== 1'b0) ? '0 : pc + 11'd1;
   end

   assign core_instruction_address_in = pc;
   assign core_instruction_in         = mem[imem_address_out];

   typedef struct { int unsigned addr; logic [15:0] data; } wr_t;
   typedef struct { bit done; int unsigned k; int unsigned halt; } run_t;

   wr_t         exp_wr_q[$];
   run_t        exp_run_q[$];
   int unsigned exp_load_q[$];
   logic [15:0] prog[$];
   logic [15:0] ref_mem [MemWords];
   int unsigned n_pass;
   int unsigned n_total;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic logic [15:0] rand_word(input bit allow_hlt);
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:11] == 5'd0) w[15:11] = 5'd1;
      if (allow_hlt && $urandom_range(0, 7) == 0) w[15:11] = 5'd0;
      return w;
   endfunction

   // Program-level model: RUN cycle c fetches address c-1; HLT beats the limit in the same cycle.
   function automatic void model_run(input int unsigned max, output bit is_done,
                                     output int unsigned k, output int unsigned halt);
      logic [15:0] w;
      is_done = 1'b0; k = 0; halt = 0;
      for (int unsigned c = 1; c <= 2 * MemWords; c++) begin
         w = ref_mem[(c - 1) % MemWords];
         if (w[15:11] == 5'd0) begin
            is_done = 1'b1; k = c; halt = (c - 1) % MemWords;
            return;
         end
         if (max != 0 && c == max) begin
            k = c;
            return;
         end
      end
   endfunction

   // Monitor
   bit          prev_ready, prev_end, end_now, saw_low_in_load;
   int unsigned low_cnt;

   always @(negedge clk) begin
      wr_t         w;
      run_t        r;
      int unsigned e;
      if (imem_wr_out === 1'b1) begin
         if (exp_wr_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                     imem_address_out, imem_data_out);
         end else begin
            w = exp_wr_q.pop_front();
            check("imem_write", 64'({imem_address_out, imem_data_out}),
                  64'({11'(w.addr), w.data}));
         end
      end
      if (reset_in === 1'b1) low_cnt = 0;
      else if (core_reset_out === 1'b0) low_cnt++;
      if (load_ready_out === 1'b1 && core_reset_out !== 1'b1) saw_low_in_load = 1'b1;
      if (prev_ready && load_ready_out !== 1'b1) begin
         if (exp_load_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_load_end: loaded_words %0d, expected no load end",
                     loaded_words_out);
         end else begin
            e = exp_load_q.pop_front();
            check("loaded_words", 64'(loaded_words_out), 64'(e));
            check("core_reset_during_load", 64'(saw_low_in_load), 64'(0));
         end
         saw_low_in_load = 1'b0;
      end
      prev_ready = (load_ready_out === 1'b1);
      end_now = (done_out === 1'b1) || (timeout_out === 1'b1);
      if (end_now && !prev_end) begin
         if (exp_run_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_run_end: done %b timeout %b, expected no end",
                     done_out, timeout_out);
         end else begin
            r = exp_run_q.pop_front();
            check("run_done_flag", 64'(done_out), 64'(r.done));
            check("run_timeout_flag", 64'(timeout_out), 64'(!r.done));
            check("cycle_count", 64'(cycle_count_out), 64'(r.k));
            check("core_released_cycles", 64'(low_cnt), 64'(r.k));
            check("core_reset_after_end", 64'(core_reset_out), 64'(1));
            if (r.done) check("halt_address", 64'(halt_address_out), 64'(r.halt));
         end
         low_cnt = 0;
      end
      prev_end = end_now;
   end

   task automatic check_reset_state(input string name);
      check(name, 64'({core_reset_out, load_ready_out, imem_wr_out, busy_out, done_out,
                       timeout_out, halt_address_out, cycle_count_out, loaded_words_out}),
            64'({1'b1, 5'b0, 11'd0, 24'd0, 12'd0}));
   endtask

   task automatic pulse_reset(input string name, input bit hold_valid);
      @(posedge clk); #1;
      reset_in = 1'b1;
      load_valid_in = hold_valid;
      load_data_in = 16'($urandom);
      @(negedge clk);
      check({name, "_no_write"}, 64'(imem_wr_out), 64'(0));
      @(posedge clk); #1;
      reset_in = 1'b0;
      load_valid_in = 1'b0;
      check_reset_state(name);
   endtask

   // gap_mode: 0 back-to-back, 1 idle cycle between every word, 2 random idle cycles.
   task automatic do_load(input int gap_mode, input bit use_last, input bit both);
      int unsigned n;
      n = prog.size();
      // A load without a last marker that is not full is ended by reset in this bench.
      exp_load_q.push_back((use_last || n == MemWords) ? n : 0);
      @(posedge clk); #1;
      load_start_in = 1'b1;
      run_start_in  = both;
      @(posedge clk); #1;
      load_start_in = 1'b0;
      run_start_in  = 1'b0;
      if (both) check("both_start_enters_load", 64'(load_ready_out), 64'(1));
      for (int unsigned i = 0; i < n; i++) begin
         load_valid_in = 1'b1;
         load_data_in  = prog[i];
         load_last_in  = use_last && (i == n - 1);
         exp_wr_q.push_back('{addr: i, data: prog[i]});
         ref_mem[i] = prog[i];
         @(posedge clk); #1;
         load_valid_in = 1'b0;
         load_last_in  = 1'b0;
         if (i != n - 1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
            load_data_in  = 16'($urandom);
            load_start_in = 1'($urandom);
            run_start_in  = 1'($urandom);
            @(posedge clk); #1;
            load_start_in = 1'b0;
            run_start_in  = 1'b0;
         end
      end
   endtask

   task automatic do_run(input int unsigned max);
      bit          d;
      int unsigned k, h, t;
      model_run(max, d, k, h);
      if (k == 0) begin
         max = 25;
         model_run(max, d, k, h);
      end
      exp_run_q.push_back('{done: d, k: k, halt: h});
      @(posedge clk); #1;
      run_start_in  = 1'b1;
      max_cycles_in = 24'(max);
      @(posedge clk); #1;
      run_start_in  = 1'b0;
      max_cycles_in = 24'($urandom);
      t = 0;
      while (!(done_out === 1'b1 || timeout_out === 1'b1) && t < k + ClearCycles + 20) begin
         @(negedge clk);
         t++;
      end
      if (!(done_out === 1'b1 || timeout_out === 1'b1)) begin
         n_total++;
         $display("FAIL run_end_wait: no done/timeout after %0d cycles, expected end at RUN cycle %0d",
                  t, k);
         void'(exp_run_q.pop_back());
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned t;
      for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = 16'hF800;
      repeat (3) @(posedge clk);
      #1 reset_in = 1'b0;
      check_reset_state("reset_initial");

      prog = '{16'h1001, 16'h2002, 16'h0000};
      do_load(0, 1'b1, 1'b0);

      prog = '{16'h0000};
      do_load(0, 1'b1, 1'b0);
      do_run(0);

      prog.delete();
      for (int i = 0; i < 5; i++) prog.push_back(rand_word(1'b0));
      prog.push_back(16'h0000);
      do_load(1, 1'b1, 1'b0);
      do_run(6);

      prog.delete();
      for (int i = 0; i < 12; i++) prog.push_back(rand_word(1'b0));
      do_load(2, 1'b1, 1'b0);
      do_run(10);

      for (int it = 0; it < 8; it++) begin
         prog.delete();
         for (int i = 0; i < int'($urandom_range(1, 20)); i++) prog.push_back(rand_word(1'b1));
         do_load(2, 1'b1, 1'b0);
         do_run($urandom_range(0, 25));
         if ($urandom_range(0, 1) == 1) do_run($urandom_range(1, 25));
      end

      prog.delete();
      for (int i = 0; i < 4; i++) prog.push_back(rand_word(1'b1));
      do_load(0, 1'b0, 1'b0);
      pulse_reset("reset_mid_load", 1'b1);

      prog.delete();
      for (int i = 0; i < 15; i++) prog.push_back(rand_word(1'b0));
      do_load(2, 1'b1, 1'b0);
      @(posedge clk); #1;
      run_start_in  = 1'b1;
      max_cycles_in = '0;
      @(posedge clk); #1;
      run_start_in = 1'b0;
      t = 0;
      while (core_reset_out !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("core_released_in_run", 64'(core_reset_out), 64'(0));
      check("busy_in_run", 64'(busy_out), 64'(1));
      repeat (3) @(negedge clk);
      pulse_reset("reset_mid_run", 1'b0);

      prog = '{16'h1234, 16'h0000};
      do_load(2, 1'b1, 1'b1);
      do_run(5);

      prog.delete();
      for (int i = 0; i < int'(MemWords); i++) prog.push_back(rand_word(1'b0));
      do_load(0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);

      check("pending_writes", 64'(exp_wr_q.size()), 64'(0));
      check("pending_runs", 64'(exp_run_q.size()), 64'(0));
      check("pending_loads", 64'(exp_load_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
